bringup_sequencer: RTL and testbench
====================================

// Module: bringup_sequencer
// PURPOSE
//  Synthesizable single-clock power-up controller for the analog front end.
//  Captures the 5-bit serial gain word, releases VCO then amplifier resets after fixed delays, and raises ready.
//  Then measures VCO frequency by counting synchronized VCO ticks over a reference window of i_clk cycles.
//  Sits between the serial config pins, the VCO tick synchronizer and the amplifier/VCO analog controls.
// PARAMETERS
//  VCO_DLY     2      i_clk cycles from gain word complete to o_resetbvco=1
//  AMP_DLY     10     cycles from o_resetbvco=1 to o_resetb1/o_resetb2=1
//  RDY_DLY     10     cycles from amp reset release to o_ready=1
//  MEAS_WIN    10000  measurement window length in i_clk cycles (>=1)
//  FREQ_SCALE  200    i_clk frequency in MHz; o_vco_freq = ticks*FREQ_SCALE/MEAS_WIN
//  CNT_W       16     tick counter width (saturating)
//  FREQ_W      11     result width
//  CFG_TIMEOUT 4096   idle-cycle limit in CFG (only with CFG_TIMEOUT_EN)
// PORTS
//  i_clk        in   1       system reference clock; all logic on rising edge
//  i_resetbAll  in   1       asynchronous, active-low reset
//  i_sclk       in   1       serial config clock; asynchronous, 2-flop synchronized internally
//  i_sdin       in   1       serial config data; 2-flop synchronized with i_sclk
//  i_vco_tick   in   1       one-cycle pulse per VCO rising edge, already in i_clk domain
//  i_recal      in   1       one-cycle pulse: rerun measurement (honoured in DONE only)
//  o_ready      out  1       front end sequenced and usable
//  o_resetb1    out  1       amplifier 1 reset, active-low
//  o_gainA1     out  2       amplifier 1 gain
//  o_resetb2    out  1       amplifier 2 reset, active-low
//  o_gainA2     out  3       amplifier 2 gain
//  o_resetbvco  out  1       VCO reset, active-low
//  o_vco_freq   out  FREQ_W  measured VCO frequency, MHz
//  o_freq_valid out  1       o_vco_freq valid
// BEHAVIOUR
//  Reset (async, any state): all outputs 0, FSM->CFG, counters, shadow reg, bit index cleared.
//  FSM: CFG -> VCO_WAIT -> AMP_WAIT -> RDY_WAIT -> MEAS -> DIV -> DONE; DONE --i_recal--> MEAS.
//  CFG: rising edge of synchronized sclk samples synchronized sdin; bits LSB-first:
//   bit0,1 -> gainA1[0],[1]; bit2..4 -> gainA2[0..2]. Held in shadow reg; o_gainA1/o_gainA2
//   load atomically on the cycle the 5th bit is captured; FSM -> VCO_WAIT same cycle.
//  sclk edges outside CFG ignored; gains never change again until reset.
//  VCO_WAIT: o_resetbvco=1 exactly VCO_DLY cycles after entry; ->AMP_WAIT.
//  AMP_WAIT: o_resetb1=o_resetb2=1 together, AMP_DLY cycles after entry; ->RDY_WAIT.
//  RDY_WAIT: o_ready=1 RDY_DLY cycles after entry; ->MEAS. o_ready stays 1 until reset.
//  MEAS: tick counter cleared on entry; counts i_vco_tick for exactly MEAS_WIN cycles incl. the
//   final window cycle; saturates at 2^CNT_W-1 (no wrap); then ->DIV.
//  DIV: iterative restoring divide, 1 quotient bit/cycle, of N=ticks*FREQ_SCALE (CNT_W+8 bits)
//   by MEAS_WIN; CNT_W+8 cycles; quotient truncated (floor); saturates to 2^FREQ_W-1 on overflow.
//  DONE: o_vco_freq loaded and o_freq_valid=1 on same cycle; held stable.
//  i_recal in DONE: o_freq_valid=0 next cycle, o_vco_freq holds old value, ->MEAS. Ignored elsewhere.
//  Ticks outside MEAS ignored. Reset mid-sequence aborts; full sequence incl. CFG reruns after release.
// CONFIGURATION
//  CFG_TIMEOUT_EN defined: in CFG, idle counter cleared on each captured bit; reaching CFG_TIMEOUT
//   idle cycles discards partial bits, gains stay 0, FSM -> VCO_WAIT. Counter also runs before bit0.
//  Not defined: CFG waits indefinitely for 5 bits; no timeout logic, CFG_TIMEOUT unused.
// TESTING
//  sdin 1,0,0,1,1 on 5 sclk edges -> o_gainA1=2'b01, o_gainA2=3'b110, both update same cycle.
//  After 5th bit -> o_resetbvco +2 cycles, o_resetb1/2 +10 later, o_ready +10 later (defaults).
//  Tick every 4th cycle, MEAS_WIN=10000 -> 2500 ticks -> o_vco_freq=50, o_freq_valid=1.
//  Tick every cycle, FREQ_W=7 -> 200 saturates -> o_vco_freq=127.
//  Reset low during AMP_WAIT -> all outputs 0 immediately; re-sent word -> full sequence repeats.
//  i_recal in DONE, new tick rate 1/8 -> valid drops, then o_vco_freq=25; recal in MEAS ignored.
//  CFG_TIMEOUT_EN, 2 bits then silence -> 4096 cycles later gains=0, o_resetbvco +2 cycles.

Source files
------------

// File: rtl/bringup_sequencer.sv
// ============================================================================
// Module   : bringup_sequencer
// Purpose  : Analog front-end power-up sequencer. Captures the serial gain
//            word, releases VCO and amplifier resets, raises ready, then
//            measures the VCO frequency over a reference window.
// Options  : CFG_TIMEOUT_EN enables an idle timeout while waiting for the
//            serial gain word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bringup_sequencer #(
  parameter int VCO_DLY    = 2,
  parameter int AMP_DLY    = 10,
  parameter int RDY_DLY    = 10,
  parameter int MEAS_WIN   = 10000,
  parameter int FREQ_SCALE = 200,
  parameter int CNT_W      = 16,
  parameter int FREQ_W     = 11
`ifdef CFG_TIMEOUT_EN
  ,
  parameter int CFG_TIMEOUT = 4096
`endif
) (
  input  logic              i_clk,
  input  logic              i_resetbAll,
  input  logic              i_sclk,
  input  logic              i_sdin,
  input  logic              i_vco_tick,
  input  logic              i_recal,
  output logic              o_ready,
  output logic              o_resetb1,
  output logic [1:0]        o_gainA1,
  output logic              o_resetb2,
  output logic [2:0]        o_gainA2,
  output logic              o_resetbvco,
  output logic [FREQ_W-1:0] o_vco_freq,
  output logic              o_freq_valid
);

  localparam int c_N_W     = CNT_W + 8;
  localparam int c_WIN_W   = $clog2(MEAS_WIN + 1);
  localparam int c_REM_W   = c_WIN_W + 1;
  localparam int c_DCNT_W  = $clog2(c_N_W);
  localparam int c_DLY_MAX = (VCO_DLY > AMP_DLY) ?
                             ((VCO_DLY > RDY_DLY) ? VCO_DLY : RDY_DLY) :
                             ((AMP_DLY > RDY_DLY) ? AMP_DLY : RDY_DLY);
  localparam int c_DLY_W   = $clog2(c_DLY_MAX + 1);

  localparam logic [c_DLY_W-1:0]  c_VCO_LAST = c_DLY_W'(VCO_DLY - 1);
  localparam logic [c_DLY_W-1:0]  c_AMP_LAST = c_DLY_W'(AMP_DLY - 1);
  localparam logic [c_DLY_W-1:0]  c_RDY_LAST = c_DLY_W'(RDY_DLY - 1);
  localparam logic [c_WIN_W-1:0]  c_WIN_LAST = c_WIN_W'(MEAS_WIN - 1);
  localparam logic [c_WIN_W-1:0]  c_WIN_D    = c_WIN_W'(MEAS_WIN);
  localparam logic [c_REM_W-1:0]  c_WIN_R    = c_REM_W'(MEAS_WIN);
  localparam logic [c_DCNT_W-1:0] c_DIV_LAST = c_DCNT_W'(c_N_W - 1);
  localparam logic [c_N_W-1:0]    c_FREQ_MAX = c_N_W'((1 << FREQ_W) - 1);
  localparam logic [c_N_W-1:0]    c_SCALE    = c_N_W'(FREQ_SCALE);

  typedef enum logic [2:0] {
    S_CFG      = 3'd0,
    S_VCO_WAIT = 3'd1,
    S_AMP_WAIT = 3'd2,
    S_RDY_WAIT = 3'd3,
    S_MEAS     = 3'd4,
    S_DIV      = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic r_sclk_meta, r_sclk_sync, r_sclk_prev;
  logic r_sdin_meta, r_sdin_sync;
  logic w_sclk_rise;

  logic [2:0]          r_bit_idx;
  logic [3:0]          r_shadow;
  logic [1:0]          r_gain_a1;
  logic [2:0]          r_gain_a2;
  logic [c_DLY_W-1:0]  r_dly_cnt;
  logic                r_resetbvco, r_resetb_amp, r_ready;
  logic [CNT_W-1:0]    r_ticks;
  logic [c_WIN_W-1:0]  r_win_cnt;
  logic [c_N_W-1:0]    r_dividend;
  logic [c_WIN_W-1:0]  r_rem;
  logic [c_N_W-2:0]    r_quot;
  logic [c_DCNT_W-1:0] r_div_cnt;
  logic [FREQ_W-1:0]   r_vco_freq;
  logic                r_freq_valid;

  logic                w_bit_last, w_cfg_timeout, w_dly_done;
  logic                w_win_last, w_div_last, w_qbit;
  logic [CNT_W-1:0]    w_ticks_next;
  logic [c_N_W-1:0]    w_product;
  logic [c_REM_W-1:0]  w_rem_shift;
  logic [c_WIN_W-1:0]  w_rem_sub;
  logic [c_N_W-1:0]    w_quot_full;

  assign w_sclk_rise = r_sclk_sync & ~r_sclk_prev;
  assign w_bit_last  = w_sclk_rise && (r_bit_idx == 3'd4);

  assign w_dly_done = ((r_state == S_VCO_WAIT) && (r_dly_cnt == c_VCO_LAST)) ||
                      ((r_state == S_AMP_WAIT) && (r_dly_cnt == c_AMP_LAST)) ||
                      ((r_state == S_RDY_WAIT) && (r_dly_cnt == c_RDY_LAST));

  assign w_win_last   = (r_win_cnt == c_WIN_LAST);
  assign w_div_last   = (r_div_cnt == c_DIV_LAST);
  assign w_ticks_next = (i_vco_tick && (r_ticks != {CNT_W{1'b1}})) ? r_ticks + 1'b1 : r_ticks;
  assign w_product    = c_N_W'(w_ticks_next) * c_SCALE;

  // Restoring division: shift one dividend bit into the partial remainder per cycle.
  assign w_rem_shift = {r_rem, r_dividend[c_N_W-1]};
  assign w_qbit      = (w_rem_shift >= c_WIN_R);
  assign w_rem_sub   = w_rem_shift[c_WIN_W-1:0] - c_WIN_D;
  assign w_quot_full = {r_quot, w_qbit};

`ifdef CFG_TIMEOUT_EN
  localparam int c_IDLE_W = $clog2(CFG_TIMEOUT + 1);
  localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(CFG_TIMEOUT - 1);

  logic [c_IDLE_W-1:0] r_idle_cnt;

  always_ff @(posedge i_clk or negedge i_resetbAll) begin
    if (!i_resetbAll) begin
      r_idle_cnt <= '0;
    end else if ((r_state != S_CFG) || w_sclk_rise) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  assign w_cfg_timeout = (r_state == S_CFG) && !w_sclk_rise && (r_idle_cnt == c_IDLE_LAST);
`else
  assign w_cfg_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_resetbAll) begin
    if (!i_resetbAll) begin
      r_state <= S_CFG;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_CFG:      if (w_bit_last || w_cfg_timeout) w_state_next = S_VCO_WAIT;
      S_VCO_WAIT: if (w_dly_done) w_state_next = S_AMP_WAIT;
      S_AMP_WAIT: if (w_dly_done) w_state_next = S_RDY_WAIT;
      S_RDY_WAIT: if (w_dly_done) w_state_next = S_MEAS;
      S_MEAS:     if (w_win_last) w_state_next = S_DIV;
      S_DIV:      if (w_div_last) w_state_next = S_DONE;
      S_DONE:     if (i_recal) w_state_next = S_MEAS;
      default:    w_state_next = S_CFG;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetbAll) begin
    if (!i_resetbAll) begin
      r_sclk_meta  <= 1'b0;
      r_sclk_sync  <= 1'b0;
      r_sclk_prev  <= 1'b0;
      r_sdin_meta  <= 1'b0;
      r_sdin_sync  <= 1'b0;
      r_bit_idx    <= '0;
      r_shadow     <= '0;
      r_gain_a1    <= '0;
      r_gain_a2    <= '0;
      r_dly_cnt    <= '0;
      r_resetbvco  <= 1'b0;
      r_resetb_amp <= 1'b0;
      r_ready      <= 1'b0;
      r_ticks      <= '0;
      r_win_cnt    <= '0;
      r_dividend   <= '0;
      r_rem        <= '0;
      r_quot       <= '0;
      r_div_cnt    <= '0;
      r_vco_freq   <= '0;
      r_freq_valid <= 1'b0;
    end else begin
      r_sclk_meta <= i_sclk;
      r_sclk_sync <= r_sclk_meta;
      r_sclk_prev <= r_sclk_sync;
      r_sdin_meta <= i_sdin;
      r_sdin_sync <= r_sdin_meta;

      if (r_state != w_state_next) begin
        r_dly_cnt <= '0;
      end else if ((r_state == S_VCO_WAIT) || (r_state == S_AMP_WAIT) ||
                   (r_state == S_RDY_WAIT)) begin
        r_dly_cnt <= r_dly_cnt + 1'b1;
      end

      case (r_state)
        S_CFG: begin
          if (w_cfg_timeout) begin
            r_shadow  <= '0;
            r_bit_idx <= '0;
          end else if (w_sclk_rise) begin
            if (r_bit_idx == 3'd4) begin
              // Both gains load together from the shadow plus the final bit.
              r_gain_a1 <= r_shadow[1:0];
              r_gain_a2 <= {r_sdin_sync, r_shadow[3:2]};
              r_bit_idx <= '0;
            end else begin
              r_shadow[r_bit_idx[1:0]] <= r_sdin_sync;
              r_bit_idx                <= r_bit_idx + 1'b1;
            end
          end
        end
        S_VCO_WAIT: begin
          if (w_dly_done) r_resetbvco <= 1'b1;
        end
        S_AMP_WAIT: begin
          if (w_dly_done) r_resetb_amp <= 1'b1;
        end
        S_RDY_WAIT: begin
          if (w_dly_done) begin
            r_ready   <= 1'b1;
            r_ticks   <= '0;
            r_win_cnt <= '0;
          end
        end
        S_MEAS: begin
          r_ticks <= w_ticks_next;
          if (w_win_last) begin
            r_dividend <= w_product;
            r_rem      <= '0;
            r_quot     <= '0;
            r_div_cnt  <= '0;
          end else begin
            r_win_cnt <= r_win_cnt + 1'b1;
          end
        end
        S_DIV: begin
          r_dividend <= {r_dividend[c_N_W-2:0], 1'b0};
          r_rem      <= w_qbit ? w_rem_sub : w_rem_shift[c_WIN_W-1:0];
          r_quot     <= w_quot_full[c_N_W-2:0];
          r_div_cnt  <= r_div_cnt + 1'b1;
          if (w_div_last) begin
            r_vco_freq   <= (w_quot_full > c_FREQ_MAX) ? {FREQ_W{1'b1}}
                                                       : w_quot_full[FREQ_W-1:0];
            r_freq_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (i_recal) begin
            r_freq_valid <= 1'b0;
            r_ticks      <= '0;
            r_win_cnt    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ready      = r_ready;
  assign o_resetb1    = r_resetb_amp;
  assign o_resetb2    = r_resetb_amp;
  assign o_gainA1     = r_gain_a1;
  assign o_gainA2     = r_gain_a2;
  assign o_resetbvco  = r_resetbvco;
  assign o_vco_freq   = r_vco_freq;
  assign o_freq_valid = r_freq_valid;

endmodule

`default_nettype wire

// File: tb/tb_bringup_sequencer.sv
// ============================================================================
// Module   : tb_bringup_sequencer
// Purpose  : Randomized self-checking bench for bringup_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bringup_sequencer;

  localparam int c_VCO_DLY  = 2;
  localparam int c_AMP_DLY  = 10;
  localparam int c_RDY_DLY  = 10;
  localparam int c_WIN      = 10000;
  localparam int c_SCALE    = 200;
  localparam int c_CNT_MAX  = 65535;
  localparam int c_DIV_CYC  = 24;
  localparam int c_SAT_WIN  = 100;
  localparam int c_SAT_FW   = 7;

  logic clk = 1'b0;
  logic rst_n, sclk, sdin, tick, recal;

  logic        ready, resetb1, resetb2, resetbvco, freq_valid;
  logic [1:0]  gain_a1;
  logic [2:0]  gain_a2;
  logic [10:0] vco_freq;

  logic        s_ready, s_resetb1, s_resetb2, s_resetbvco, s_freq_valid;
  logic [1:0]  s_gain_a1;
  logic [2:0]  s_gain_a2;
  logic [6:0]  s_vco_freq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bringup_sequencer u_dut (
    .i_clk(clk), .i_resetbAll(rst_n), .i_sclk(sclk), .i_sdin(sdin),
    .i_vco_tick(tick), .i_recal(recal),
    .o_ready(ready), .o_resetb1(resetb1), .o_gainA1(gain_a1),
    .o_resetb2(resetb2), .o_gainA2(gain_a2), .o_resetbvco(resetbvco),
    .o_vco_freq(vco_freq), .o_freq_valid(freq_valid)
  );

  // Second instance: tick on every cycle, short window, narrow result -> saturates.
  bringup_sequencer #(.MEAS_WIN(c_SAT_WIN), .FREQ_W(c_SAT_FW)) u_dut_sat (
    .i_clk(clk), .i_resetbAll(rst_n), .i_sclk(sclk), .i_sdin(sdin),
    .i_vco_tick(1'b1), .i_recal(1'b0),
    .o_ready(s_ready), .o_resetb1(s_resetb1), .o_gainA1(s_gain_a1),
    .o_resetb2(s_resetb2), .o_gainA2(s_gain_a2), .o_resetbvco(s_resetbvco),
    .o_vco_freq(s_vco_freq), .o_freq_valid(s_freq_valid)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_freq(input int ticks, input int win, input int fw);
    longint q;
    int     t;
    t = (ticks > c_CNT_MAX) ? c_CNT_MAX : ticks;
    q = (longint'(t) * c_SCALE) / win;
    if (q > (longint'(1) << fw) - 1) q = (longint'(1) << fw) - 1;
    return int'(q);
  endfunction

  function automatic logic get_sig(input int sel);
    case (sel)
      0:       return resetbvco;
      1:       return resetb1;
      2:       return ready;
      default: return freq_valid;
    endcase
  endfunction

  // Steps until the selected output is high; ticks meanwhile are noise.
  task automatic wait_high(input int sel, input int bound, output int n);
    n = 0;
    while (!get_sig(sel) && n < bound) begin
      tick = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    tick = 1'b0;
  endtask

  task automatic send_word(input logic [4:0] w, input bit expect_load);
    bit found;
    for (int b = 0; b < 5; b++) begin
      sdin = w[b];
      sclk = 1'b0;
      repeat (4) step();
      sclk = 1'b1;
      if (b == 4 && expect_load) begin
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
          step();
          if (gain_a1 != 2'd0 || gain_a2 != 3'd0) found = 1'b1;
        end
        check("gain_load_seen", int'(found), 1);
        check("gainA1", int'(gain_a1), int'({w[1], w[0]}));
        check("gainA2", int'(gain_a2), int'({w[4], w[3], w[2]}));
      end else begin
        repeat (4) step();
      end
    end
    sclk = 1'b0;
  endtask

  task automatic run_sequence(input logic [4:0] w);
    int n;
    send_word(w, 1'b1);
    wait_high(0, 50, n);
    check("vco_release_delay", n, c_VCO_DLY);
    check("amp_still_reset", int'(resetb1), 0);
    wait_high(1, 50, n);
    check("amp_release_delay", n, c_AMP_DLY);
    check("resetb2_with_resetb1", int'(resetb2), 1);
    wait_high(2, 50, n);
    check("ready_delay", n, c_RDY_DLY);
  endtask

  // Called right after MEAS entry; period 0 selects random ticks.
  task automatic measure(input string tag, input int period, input bit poke_recal);
    int cnt, n, dens;
    cnt  = 0;
    dens = $urandom_range(5, 95);
    for (int i = 0; i < c_WIN; i++) begin
      if (period > 0) tick = ((i % period) == 0);
      else            tick = ($urandom_range(0, 99) < dens);
      recal = poke_recal && (i == c_WIN / 2);
      if (tick) cnt++;
      step();
    end
    recal = 1'b0;
    wait_high(3, 100, n);
    check({tag, "_div_latency"}, n, c_DIV_CYC);
    check({tag, "_freq"}, int'(vco_freq), exp_freq(cnt, c_WIN, 11));
  endtask

  task automatic do_recal();
    int old;
    old   = int'(vco_freq);
    recal = 1'b1;
    step();
    recal = 1'b0;
    check("recal_valid_drop", int'(freq_valid), 0);
    check("recal_freq_hold", int'(vco_freq), old);
  endtask

  function automatic logic [4:0] rand_word();
    logic [4:0] w;
    do w = 5'($urandom_range(0, 31)); while (w[1:0] == 2'd0 || w[4:2] == 3'd0);
    return w;
  endfunction

  function automatic int all_outs();
    return int'({ready, resetb1, gain_a1, resetb2, gain_a2, resetbvco, vco_freq, freq_valid,
                 s_ready, s_resetb1, s_gain_a1, s_resetb2, s_gain_a2, s_resetbvco,
                 s_vco_freq, s_freq_valid});
  endfunction

  initial begin
    int old_freq, n;
    logic [1:0] a1;
    logic [2:0] a2;
    rst_n = 1'b0; sclk = 1'b0; sdin = 1'b0; tick = 1'b0; recal = 1'b0;
    repeat (3) step();
    check("reset_outputs", all_outs(), 0);
    rst_n = 1'b1;
    repeat (2) step();

    // Word sent LSB-first as 1,0,0,1,1.
    run_sequence(5'b11001);
    check("gainA1_spec", int'(gain_a1), 1);
    check("gainA2_spec", int'(gain_a2), 6);
    measure("tick_div4", 4, 1'b0);
    check("sat_valid", int'(s_freq_valid), 1);
    check("sat_freq", int'(s_vco_freq), exp_freq(c_SAT_WIN, c_SAT_WIN, c_SAT_FW));

    old_freq = int'(vco_freq);
    a1 = gain_a1;
    a2 = gain_a2;
    send_word(5'b00110, 1'b0);
    check("gainA1_locked", int'(gain_a1), int'(a1));
    check("gainA2_locked", int'(gain_a2), int'(a2));
    check("done_valid_held", int'(freq_valid), 1);
    check("done_freq_held", int'(vco_freq), old_freq);

    do_recal();
    measure("tick_div8_recal_in_meas", 8, 1'b1);
    do_recal();
    measure("tick_random", 0, 1'b0);
    check("ready_sticky", int'(ready), 1);

    // Restart, then abort asynchronously in the amplifier wait.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    send_word(rand_word(), 1'b1);
    wait_high(0, 50, n);
    check("abort_vco_delay", n, c_VCO_DLY);
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", all_outs(), 0);
    step();
    rst_n = 1'b1;
    repeat (2) step();
    check("post_reset_outputs", all_outs(), 0);

    run_sequence(rand_word());
    measure("rerun_random", 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
